if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 83 ++++++++
 tb/tb_if_id_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - two-entry fetch-to-decode instruction queue with HALT and flush
// Occupancy doubles as the state; outputs come only from registered storage.
module if_id_queue #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc_inc,
  output logic        if_ready,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_inc,
  input  logic        flush,
  output logic        halted,
  output logic [1:0]  count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        halted_q;
  logic [15:0] mem_instr [2];
  logic [15:0] mem_pc    [2];
  logic        push;
  logic        pop;

  assign if_ready = (count_q != ST_FULL) & ~halted_q;
  assign id_valid = (count_q != ST_EMPTY);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  assign id_instr  = id_valid ? mem_instr[rd_ptr] : NOP_INSTR;
  assign id_pc_inc = id_valid ? mem_pc[rd_ptr]    : 16'h0000;
  assign halted    = halted_q;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    case (count_q)
      ST_EMPTY: if (push)         count_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)         count_d = ST_FULL;
        else if (pop && !push)    count_d = ST_EMPTY;
      end
      ST_FULL:  if (pop)          count_d = ST_ONE;
      default:                    count_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q  <= ST_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr <= ~wr_ptr;
        if (if_instr[15:11] == HALT_OPC) halted_q <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Storage is never cleared; stale words are hidden by the count mask.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_instr[wr_ptr] <= if_instr;
      mem_pc[wr_ptr]    <= if_pc_inc;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = 16'h0;
  logic [15:0] if_pc_inc = 16'h0;
  logic        if_ready;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_inc;
  logic        flush = 1'b0;
  logic        halted;
  logic [1:0]  count;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  entry_t sb[$];
  logic   mh = 1'b0;
  int     checks = 0;
  int     errors = 0;

  if_id_queue dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_inc(if_pc_inc), .if_ready(if_ready),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc_inc(id_pc_inc),
    .flush(flush), .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the reference queue from the inputs seen at the edge.
  task automatic tick();
    logic do_push;
    logic do_pop;
    do_push = if_valid && (sb.size() != 2) && !mh;
    do_pop  = (sb.size() != 0) && id_ready;
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
      mh = 1'b0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back({if_instr, if_pc_inc});
        if (if_instr[15:11] == 5'b00000) mh = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [15:0] pc);
    if_valid = 1'b1; if_instr = instr; if_pc_inc = pc; id_ready = 1'b0;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
    checks++; if (id_instr !== 16'h0800) begin errors++; $display("FAIL reset_id_instr got %h exp 0800", id_instr); end
    checks++; if (id_pc_inc !== 16'h0000) begin errors++; $display("FAIL reset_id_pc got %h exp 0000", id_pc_inc); end
    checks++; if (if_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL reset_ready_halt got %b%b exp 10", if_ready, halted); end
  endtask

  task automatic test_single_push();
    push_one(16'h4A21, 16'h0002);
    checks++; if (id_valid !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL single_state got v=%b c=%0d exp v=1 c=1", id_valid, count); end
    checks++; if (id_instr !== sb[0].instr || id_instr !== 16'h4A21) begin errors++; $display("FAIL single_instr got %h exp 4a21", id_instr); end
    checks++; if (id_pc_inc !== sb[0].pc || id_pc_inc !== 16'h0002) begin errors++; $display("FAIL single_pc got %h exp 0002", id_pc_inc); end
    id_ready = 1'b1; tick(); id_ready = 1'b0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", count); end
  endtask

  task automatic test_fill_drain();
    push_one(16'h1111, 16'h0010);
    push_one(16'h2222, 16'h0012);
    checks++; if (count !== 2'd2 || if_ready !== 1'b0) begin errors++; $display("FAIL full_state got c=%0d r=%b exp c=2 r=0", count, if_ready); end
    push_one(16'h5555, 16'h0014);
    checks++; if (count !== 2'd2 || sb.size() != 2) begin errors++; $display("FAIL full_ignore got c=%0d exp 2", count); end
    id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (id_instr !== sb[0].instr || id_pc_inc !== sb[0].pc) begin
        errors++; $display("FAIL drain_%0d got %h/%h exp %h/%h", i, id_instr, id_pc_inc, sb[0].instr, sb[0].pc);
      end
      tick();
    end
    id_ready = 1'b0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || id_instr !== 16'h0800) begin errors++; $display("FAIL drain_empty got c=%0d i=%h exp c=0 i=0800", count, id_instr); end
  endtask

  task automatic test_push_pop_wrap();
    push_one(16'h3000, 16'h0020);
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_instr = 16'h3333 + 16'(i); if_pc_inc = 16'h0022 + 16'(2 * i); id_ready = 1'b1;
      checks++;
      if (id_instr !== sb[0].instr) begin errors++; $display("FAIL wrap_pop_%0d got %h exp %h", i, id_instr, sb[0].instr); end
      tick();
      checks++;
      if (count !== 2'd1 || id_instr !== 16'h3333 + 16'(i) || id_pc_inc !== sb[0].pc) begin
        errors++; $display("FAIL wrap_head_%0d got c=%0d i=%h exp c=1 i=%h", i, count, id_instr, 16'h3333 + 16'(i));
      end
    end
    if_valid = 1'b0; tick(); id_ready = 1'b0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", count); end
  endtask

  task automatic test_halt();
    push_one(16'h0000, 16'h0030);
    checks++; if (halted !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL halt_set got h=%b r=%b exp h=1 r=0", halted, if_ready); end
    checks++; if (id_instr !== 16'h0000 || id_valid !== 1'b1) begin errors++; $display("FAIL halt_head got %h exp 0000", id_instr); end
    push_one(16'h7777, 16'h0032);
    checks++; if (count !== 2'd1 || count !== 2'(sb.size())) begin errors++; $display("FAIL halt_reject got %0d exp 1", count); end
    id_ready = 1'b1;
    checks++; if (id_instr !== sb[0].instr) begin errors++; $display("FAIL halt_pop got %h exp %h", id_instr, sb[0].instr); end
    tick(); id_ready = 1'b0;
    checks++; if (count !== 2'd0 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold got c=%0d h=%b exp c=0 h=1", count, halted); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (halted !== 1'b0 || count !== 2'd0 || if_ready !== 1'b1) begin errors++; $display("FAIL halt_flush got h=%b c=%0d r=%b exp 0 0 1", halted, count, if_ready); end
  endtask

  task automatic test_flush_full();
    push_one(16'hA001, 16'h0040);
    push_one(16'hA002, 16'h0042);
    flush = 1'b1; if_valid = 1'b1; if_instr = 16'hBEEF; if_pc_inc = 16'h0044; id_ready = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_full got c=%0d v=%b exp 0 0", count, id_valid); end
    tick();
    checks++; if (count !== 2'd0 || id_instr !== 16'h0800) begin errors++; $display("FAIL flush_absent got c=%0d i=%h exp 0 0800", count, id_instr); end
    push_one(16'hC0DE, 16'h0046);
    checks++; if (id_instr !== 16'hC0DE || id_pc_inc !== sb[0].pc) begin errors++; $display("FAIL flush_reuse got %h exp c0de", id_instr); end
    id_ready = 1'b1; tick(); id_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_one(16'h1234, 16'h0050);
    push_one(16'h07FF, 16'h0052);
    checks++; if (count !== 2'd2 || halted !== 1'b1) begin errors++; $display("FAIL mid_pre got c=%0d h=%b exp 2 1", count, halted); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (count !== 2'd0 || halted !== 1'b0) begin errors++; $display("FAIL mid_rst got c=%0d h=%b exp 0 0", count, halted); end
    checks++; if (id_instr !== 16'h0800 || if_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_out got i=%h r=%b exp 0800 1", id_instr, if_ready); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_push_pop_wrap();
    test_halt();
    test_flush_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
